fracnet_t_sdiv_25s_9s_16_seq: RTL and testbench
===============================================

FRACNET_T_SDIV_25S_9S_16_SEQ -- requirements
Module: fracnet_t_sdiv_25s_9s_16_seq

Interface
REQ-001 Parameter ID, default 32'd1: instance identifier, no functional effect.
REQ-002 Parameter din0_WIDTH, default 32'd25: dividend width.
REQ-003 Parameter din1_WIDTH, default 32'd9: divisor width.
REQ-004 Parameter dout_WIDTH, default 32'd16: quotient width.
REQ-005 clk  input  1: sole clock, rising edge.
REQ-006 reset  input  1: synchronous, active-high reset.
REQ-007 ce  input  1: clock enable; all state advances only when ce=1.
REQ-008 start  input  1: request; sampled only in IDLE with ce=1.
REQ-009 din0  input  din0_WIDTH: signed dividend, captured on accepted start.
REQ-010 din1  input  din1_WIDTH: signed divisor, captured on accepted start.
REQ-011 busy  output  1: high from accepted start until done.
REQ-012 done  output  1: one-ce-cycle pulse, result valid.
REQ-013 dout  output  dout_WIDTH: signed quotient, held until next done.
REQ-014 rem  output  din1_WIDTH: signed remainder, held until next done.
REQ-015 ovf  output  1: quotient saturated, valid with dout.
REQ-016 div0  output  1: divisor was zero, valid with dout.

Function
REQ-017 FSM states IDLE, CALC, FIX, DONE; transitions only on ce=1 edges.
REQ-018 IDLE->CALC on start=1: latch operand magnitudes and signs, clear iteration counter, busy=1.
REQ-019 CALC: one restoring shift-subtract step per ce cycle on magnitudes; exactly din0_WIDTH (25) steps, then ->FIX.
REQ-020 FIX: apply signs, saturate, register dout/rem/ovf/div0, ->DONE.
REQ-021 DONE: done=1, busy=0 for one ce cycle, ->IDLE; start in DONE ignored.
REQ-022 Latency: done high after the 27th ce-enabled edge following the edge accepting start; next start accepted the following ce cycle.
REQ-023 Quotient truncates toward zero; remainder sign equals dividend sign; |rem| < |din1|.
REQ-024 Internal magnitude arithmetic 25 bits dividend, 9 bits divisor+1 guard; -2^24 and -256 handled without wrap.
REQ-025 True quotient > 32767 -> dout=0x7FFF, ovf=1; < -32768 -> dout=0x8000, ovf=1; rem is exact remainder.
REQ-026 din1=0 -> div0=1, ovf=0, rem=0, dout=0x7FFF if din0>=0 else 0x8000; same latency.
REQ-027 start while busy has no effect; operands not re-sampled.
REQ-028 ce=0 freezes FSM, counter, datapath and all outputs including done level.

Reset
REQ-029 reset=1 at a rising edge (regardless of ce) forces IDLE, counter=0, busy=0, done=0, dout=0, rem=0, ovf=0, div0=0.
REQ-030 Reset mid-CALC/FIX aborts the operation; no done is produced for it.
REQ-031 reset has priority over start on the same edge.

Structure
REQ-032 Shared package holds width constants (25, 9, 16), saturation limits, FSM state enum.
REQ-033 One sub-module, fracnet_t_sdiv_25s_9s_16_seq_core (FSM + datapath); top is a thin parameterised wrapper.

Verification
REQ-034 din0=1000, din1=7, start -> done at 27th ce edge, dout=142, rem=6, ovf=0, div0=0.
REQ-035 din0=-1000, din1=7 -> dout=-142, rem=-6; din0=-2^24, din1=-256 -> dout=0x7FFF, ovf=1, rem=0.
REQ-036 din0=100000, din1=-3 -> dout=0x8000 (-32768), ovf=1, rem=1.
REQ-037 din0=5, din1=0 -> dout=0x7FFF, div0=1, rem=0; din0=-5, din1=0 -> dout=0x8000.
REQ-038 1000/7 with ce low every other cycle -> done after 27 ce-enabled edges, same result; start pulsed mid-CALC ignored.
REQ-039 reset at CALC step 10 -> all outputs 0, IDLE, no done; fresh start then completes normally.

Source files
------------

// File: rtl/fracnet_t_sdiv_25s_9s_16_seq_pkg.sv
// Shared definitions for the sequential signed divider (25-bit / 9-bit -> 16-bit).
// Holds the operand and result widths, the quotient saturation limits and the
// controller state encoding used by the core.
package fracnet_t_sdiv_25s_9s_16_seq_pkg;

    localparam int DIN0_W = 25;
    localparam int DIN1_W = 9;
    localparam int DOUT_W = 16;
    localparam int CNT_W  = 5;

    // The counter value at which the final shift-subtract step is taken.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIN0_W - 1);

    // Saturated quotient codes.
    localparam logic [DOUT_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DOUT_W-1:0] SAT_NEG = 16'h8000;

    // Largest quotient magnitudes representable in each direction.
    localparam logic [DIN0_W-1:0] QMAG_POS_MAX = 25'd32767;
    localparam logic [DIN0_W-1:0] QMAG_NEG_MAX = 25'd32768;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/fracnet_t_sdiv_25s_9s_16_seq_core.sv
// Controller and datapath of the sequential signed divider.
// A restoring divider works on operand magnitudes, one quotient bit per
// clock-enabled cycle, then signs are reapplied and the quotient saturated.
// Ports:
//   clk, reset (sync, active high), ce (clock enable)
//   start, din0 (signed dividend), din1 (signed divisor)
//   busy, done (one-cycle pulse), dout (signed quotient), rem (signed remainder),
//   ovf (quotient saturated), div0 (divisor was zero)
import fracnet_t_sdiv_25s_9s_16_seq_pkg::*;

module fracnet_t_sdiv_25s_9s_16_seq_core (
    input  logic              clk,
    input  logic              reset,
    input  logic              ce,
    input  logic              start,
    input  logic [DIN0_W-1:0] din0,
    input  logic [DIN1_W-1:0] din1,
    output logic              busy,
    output logic              done,
    output logic [DOUT_W-1:0] dout,
    output logic [DIN1_W-1:0] rem,
    output logic              ovf,
    output logic              div0
);

    state_t state, state_next;

    // quo starts as the dividend magnitude; its MSB feeds the partial
    // remainder each step while quotient bits fill in from the bottom.
    logic [DIN0_W-1:0] quo;
    logic [DIN1_W-1:0] dvs;
    logic [DIN1_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q;
    logic              neg_r;
    logic              zero_div;

    logic [DIN0_W-1:0] mag0;
    logic [DIN1_W-1:0] mag1;
    logic [DIN1_W:0]   shifted;
    logic [DIN1_W+1:0] diff;
    logic              take;
    logic [DIN1_W-1:0] acc_next;

    logic [DOUT_W-1:0] dout_fix;
    logic [DIN1_W-1:0] rem_fix;
    logic              ovf_fix;

    // The magnitudes are unsigned, so -2^24 and -256 become 2^24 and 256
    // without wrapping.
    assign mag0 = din0[DIN0_W-1] ? (~din0) + DIN0_W'(1) : din0;
    assign mag1 = din1[DIN1_W-1] ? (~din1) + DIN1_W'(1) : din1;

    // Restoring step: the partial remainder is kept below the divisor, so
    // the shifted value fits DIN1_W+1 bits and one extra bit gives the
    // borrow.
    assign shifted  = {acc, quo[DIN0_W-1]};
    assign diff     = {1'b0, shifted} - {2'b00, dvs};
    assign take     = ~diff[DIN1_W+1];
    assign acc_next = take ? diff[DIN1_W-1:0] : shifted[DIN1_W-1:0];

    assign busy = (state != S_IDLE);

    // Sign application and saturation of the finished magnitudes.
    always_comb begin
        dout_fix = '0;
        rem_fix  = neg_r ? (~acc) + DIN1_W'(1) : acc;
        ovf_fix  = 1'b0;
        if (zero_div) begin
            dout_fix = neg_r ? SAT_NEG : SAT_POS;
            rem_fix  = '0;
        end else if (!neg_q) begin
            if (quo > QMAG_POS_MAX) begin
                dout_fix = SAT_POS;
                ovf_fix  = 1'b1;
            end else begin
                dout_fix = quo[DOUT_W-1:0];
            end
        end else begin
            if (quo > QMAG_NEG_MAX) begin
                dout_fix = SAT_NEG;
                ovf_fix  = 1'b1;
            end else begin
                dout_fix = (~quo[DOUT_W-1:0]) + DOUT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_CALC;
            S_CALC: if (cnt == LAST_STEP) state_next = S_FIX;
            S_FIX:  state_next = S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // done is registered on leaving DONE so the pulse coincides with busy
    // dropping and a new start can be taken in that same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            quo      <= '0;
            dvs      <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            zero_div <= 1'b0;
            done     <= 1'b0;
            dout     <= '0;
            rem      <= '0;
            ovf      <= 1'b0;
            div0     <= 1'b0;
        end else if (ce) begin
            state <= state_next;
            done  <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quo      <= mag0;
                        dvs      <= mag1;
                        acc      <= '0;
                        cnt      <= '0;
                        neg_q    <= din0[DIN0_W-1] ^ din1[DIN1_W-1];
                        neg_r    <= din0[DIN0_W-1];
                        zero_div <= (din1 == '0);
                    end
                end
                S_CALC: begin
                    acc <= acc_next;
                    quo <= {quo[DIN0_W-2:0], take};
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    dout <= dout_fix;
                    rem  <= rem_fix;
                    ovf  <= ovf_fix;
                    div0 <= zero_div;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fracnet_t_sdiv_25s_9s_16_seq.sv
// Top-level wrapper of the sequential signed divider. Exposes the
// parameterised interface and forwards everything to the core.
// Ports:
//   clk, reset (sync, active high), ce, start, din0, din1
//   busy, done, dout, rem, ovf, div0
// ID only names the instance; the width parameters are expected to keep
// their defaults, which match the core's fixed widths.
import fracnet_t_sdiv_25s_9s_16_seq_pkg::*;

module fracnet_t_sdiv_25s_9s_16_seq #(
    parameter int unsigned ID         = 32'd1,
    parameter int unsigned din0_WIDTH = 32'd25,
    parameter int unsigned din1_WIDTH = 32'd9,
    parameter int unsigned dout_WIDTH = 32'd16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  div0
);

    fracnet_t_sdiv_25s_9s_16_seq_core u_core (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .div0  (div0)
    );

endmodule

// File: tb/tb_fracnet_t_sdiv_25s_9s_16_seq.sv
// Directed self-checking bench for the sequential signed divider.
// Drives hand-computed division cases, clock-enable gaps, ignored starts,
// and a mid-operation reset; expected values are written out by hand.
module tb_fracnet_t_sdiv_25s_9s_16_seq;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        start;
    logic [24:0] din0;
    logic [8:0]  din1;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [8:0]  rem;
    logic        ovf;
    logic        div0;

    int compared   = 0;
    int mismatched = 0;

    fracnet_t_sdiv_25s_9s_16_seq #(
        .ID         (32'd1),
        .din0_WIDTH (32'd25),
        .din1_WIDTH (32'd9),
        .dout_WIDTH (32'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .busy  (busy),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .div0  (div0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison point: counts it and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkResult(input string tag, input logic [15:0] exp_dout, input logic [8:0] exp_rem,
                               input logic exp_ovf, input logic exp_div0);
        checkOutput({tag, "_dout"}, 32'(dout), 32'(exp_dout));
        checkOutput({tag, "_rem"},  32'(rem),  32'(exp_rem));
        checkOutput({tag, "_ovf"},  32'(ovf),  32'(exp_ovf));
        checkOutput({tag, "_div0"}, 32'(div0), 32'(exp_div0));
    endtask

    // Starts one division and counts ce-enabled edges until the 27th.
    // In gappy mode ce is low every other cycle and a second start with
    // different operands is pulsed mid-calculation.
    task automatic applyStimulus(input string tag, input logic [24:0] a, input logic [8:0] b, input bit gappy);
        int ce_edges;
        int cycles;
        @(negedge clk);
        din0  = a;
        din1  = b;
        start = 1'b1;
        ce    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        ce_edges = 0;
        cycles   = 0;
        while (ce_edges < 27 && cycles < 200) begin
            ce    = gappy ? (cycles % 2 == 0) : 1'b1;
            start = gappy && (cycles == 20);
            if (start) begin
                din0 = 25'd50;
                din1 = 9'd5;
            end
            @(posedge clk);
            cycles++;
            if (ce) ce_edges++;
            @(negedge clk);
            if (ce && ce_edges == 26) begin
                checkOutput({tag, "_done_early"}, 32'(done), 32'd0);
                checkOutput({tag, "_busy_26"},    32'(busy), 32'd1);
            end
        end
        start = 1'b0;
        checkOutput({tag, "_latency"},   32'(ce_edges), 32'd27);
        checkOutput({tag, "_done"},      32'(done),     32'd1);
        checkOutput({tag, "_busy_done"}, 32'(busy),     32'd0);
    endtask

    // Closes the done pulse; with hold set, first shows ce=0 keeps it high.
    task automatic finishOp(input string tag, input bit hold);
        if (hold) begin
            ce = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, "_done_held"}, 32'(done), 32'd1);
        end
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int done_seen;

        // Reset with ce low and start high: reset must win.
        reset = 1'b1;
        ce    = 1'b0;
        start = 1'b1;
        din0  = 25'd1000;
        din1  = 9'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkResult("rst", 16'h0000, 9'h000, 1'b0, 1'b0);
        ce = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_prio_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_busy", 32'(busy), 32'd0);

        $display("[TB] basic quotients");
        applyStimulus("p1000_7", 25'd1000, 9'd7, 1'b0);
        checkResult("p1000_7", 16'd142, 9'd6, 1'b0, 1'b0);
        finishOp("p1000_7", 1'b0);

        applyStimulus("n1000_7", -25'sd1000, 9'd7, 1'b0);
        checkResult("n1000_7", 16'hFF72, 9'h1FA, 1'b0, 1'b0);
        finishOp("n1000_7", 1'b0);

        applyStimulus("n229_10", -25'sd229, 9'd10, 1'b0);
        checkResult("n229_10", 16'hFFEA, 9'h1F7, 1'b0, 1'b0);
        finishOp("n229_10", 1'b0);

        applyStimulus("p255_n256", 25'd255, 9'h100, 1'b0);
        checkResult("p255_n256", 16'h0000, 9'h0FF, 1'b0, 1'b0);
        finishOp("p255_n256", 1'b0);

        $display("[TB] saturation boundaries");
        applyStimulus("nmax_nmin", 25'h1000000, 9'h100, 1'b0);
        checkResult("nmax_nmin", 16'h7FFF, 9'h000, 1'b1, 1'b0);
        finishOp("nmax_nmin", 1'b0);

        applyStimulus("p100000_n3", 25'd100000, -9'sd3, 1'b0);
        checkResult("p100000_n3", 16'h8000, 9'd1, 1'b1, 1'b0);
        finishOp("p100000_n3", 1'b0);

        applyStimulus("n32768_1", -25'sd32768, 9'd1, 1'b0);
        checkResult("n32768_1", 16'h8000, 9'h000, 1'b0, 1'b0);
        finishOp("n32768_1", 1'b0);

        applyStimulus("p32768_1", 25'd32768, 9'd1, 1'b0);
        checkResult("p32768_1", 16'h7FFF, 9'h000, 1'b1, 1'b0);
        finishOp("p32768_1", 1'b0);

        $display("[TB] divide by zero");
        applyStimulus("p5_0", 25'd5, 9'd0, 1'b0);
        checkResult("p5_0", 16'h7FFF, 9'h000, 1'b0, 1'b1);
        finishOp("p5_0", 1'b0);

        applyStimulus("n5_0", -25'sd5, 9'd0, 1'b0);
        checkResult("n5_0", 16'h8000, 9'h000, 1'b0, 1'b1);
        finishOp("n5_0", 1'b0);

        $display("[TB] clock enable gaps");
        applyStimulus("gap1000_7", 25'd1000, 9'd7, 1'b1);
        checkResult("gap1000_7", 16'd142, 9'd6, 1'b0, 1'b0);
        finishOp("gap1000_7", 1'b1);

        $display("[TB] reset mid-calculation");
        @(negedge clk);
        din0  = 25'd1000;
        din1  = 9'd7;
        start = 1'b1;
        ce    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        checkOutput("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkResult("abort", 16'h0000, 9'h000, 1'b0, 1'b0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", 32'(done_seen), 32'd0);

        applyStimulus("after_abort", 25'd1000, 9'd7, 1'b0);
        checkResult("after_abort", 16'd142, 9'd6, 1'b0, 1'b0);
        finishOp("after_abort", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
